// File: rtl/sopc_mem_arbiter.sv
// sopc_mem_arbiter: arbitrates the instruction-fetch and data ports onto one
// synchronous single-port memory with WAIT_STATES extra cycles per access.
// Data requests win over fetches. Responses are a one-cycle ack per port.
// Optional macro MISALIGN_CHK_EN: misaligned data requests are answered with
// d_ack_o/d_err_o and never reach the memory.
module sopc_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_data_o,
  output logic                  if_ack_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_W/8-1:0]   d_sel_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic                  stall_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [DATA_W/8-1:0]   mem_sel_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int LSB   = $clog2(SEL_W);
  // Clears the byte-offset bits so the memory always sees a word address.
  localparam logic [ADDR_W-1:0] AMASK = {ADDR_W{1'b1}} << LSB;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_gnt_d;   // 1 = data port owns the current access
  logic              r_we;
  logic [SEL_W-1:0]  r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_mis;
  logic w_access;
  logic w_resp;

`ifdef MISALIGN_CHK_EN
  // Flag word accesses off a word boundary and halfword accesses on odd bytes.
  always_comb begin
    w_mis = 1'b0;
    if ((d_sel_i == {SEL_W{1'b1}}) && (d_addr_i[1:0] != 2'b00))
      w_mis = 1'b1;
    for (int b = 0; b + 1 < SEL_W; b += 2)
      if ((d_sel_i == (SEL_W'(2'b11) << b)) && d_addr_i[0])
        w_mis = 1'b1;
  end
`else
  assign w_mis = 1'b0;
`endif

  // Arbitration FSM: latch the winner in IDLE, count wait states, respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_gnt_d   <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_if_data <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'(WAIT_STATES);
          if (d_req_i) begin
            // Data access belongs to an older instruction, so it goes first.
            r_gnt_d <= 1'b1;
            r_we    <= d_we_i;
            r_sel   <= d_sel_i;
            r_addr  <= d_addr_i;
            r_wdata <= d_wdata_i;
            r_err   <= w_mis;
            r_state <= w_mis ? S_RESP : S_ACCESS;
          end else if (if_req_i) begin
            r_gnt_d <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= {SEL_W{1'b1}};
            r_addr  <= if_addr_i;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_gnt_d)  r_if_data <= mem_rdata_i;
            else if (!r_we) r_d_rdata <= mem_rdata_i;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);

  assign mem_ce_o    = w_access;
  assign mem_we_o    = w_access & r_we;
  assign mem_sel_o   = w_access ? r_sel : '0;
  assign mem_addr_o  = w_access ? (r_addr & AMASK) : '0;
  assign mem_wdata_o = w_access ? r_wdata : '0;

  assign if_ack_o  = w_resp & ~r_gnt_d;
  assign d_ack_o   = w_resp & r_gnt_d;
`ifdef MISALIGN_CHK_EN
  assign d_err_o   = d_ack_o & r_err;
`else
  assign d_err_o   = 1'b0 & r_err;
`endif
  assign if_data_o = r_if_data;
  assign d_rdata_o = r_d_rdata;

  // Stall is masked during reset so the pipeline is released immediately.
  assign stall_o = rst & ((d_req_i & ~d_ack_o) | (if_req_i & ~if_ack_o));

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter: main instance with WAIT_STATES=1 plus
// WAIT_STATES=0 and WAIT_STATES=3 instances for latency checks.
module tb_sopc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_req0 = 1'b0, if_req3 = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0, d_wdata = '0, mem_rdata = '0;

  logic [31:0] if_data, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, d_err, stall, mem_ce, mem_we;
  logic [3:0]  mem_sel;

  logic [31:0] u0_if_data, u0_d_rdata, u0_mem_addr, u0_mem_wdata;
  logic        u0_if_ack, u0_d_ack, u0_d_err, u0_stall, u0_mem_ce, u0_mem_we;
  logic [3:0]  u0_mem_sel;
  logic [31:0] u3_if_data, u3_d_rdata, u3_mem_addr, u3_mem_wdata;
  logic        u3_if_ack, u3_d_ack, u3_d_err, u3_stall, u3_mem_ce, u3_mem_we;
  logic [3:0]  u3_mem_sel;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr),
    .if_data_o(if_data), .if_ack_o(if_ack), .d_req_i(d_req), .d_we_i(d_we),
    .d_sel_i(d_sel), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(d_rdata),
    .d_ack_o(d_ack), .d_err_o(d_err), .stall_o(stall), .mem_ce_o(mem_ce),
    .mem_we_o(mem_we), .mem_sel_o(mem_sel), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata));

  sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .if_req_i(if_req0), .if_addr_i(if_addr),
    .if_data_o(u0_if_data), .if_ack_o(u0_if_ack), .d_req_i(1'b0), .d_we_i(d_we),
    .d_sel_i(d_sel), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(u0_d_rdata),
    .d_ack_o(u0_d_ack), .d_err_o(u0_d_err), .stall_o(u0_stall), .mem_ce_o(u0_mem_ce),
    .mem_we_o(u0_mem_we), .mem_sel_o(u0_mem_sel), .mem_addr_o(u0_mem_addr),
    .mem_wdata_o(u0_mem_wdata), .mem_rdata_i(mem_rdata));

  sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .if_req_i(if_req3), .if_addr_i(if_addr),
    .if_data_o(u3_if_data), .if_ack_o(u3_if_ack), .d_req_i(1'b0), .d_we_i(d_we),
    .d_sel_i(d_sel), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(u3_d_rdata),
    .d_ack_o(u3_d_ack), .d_err_o(u3_d_err), .stall_o(u3_stall), .mem_ce_o(u3_mem_ce),
    .mem_we_o(u3_mem_we), .mem_sel_o(u3_mem_sel), .mem_addr_o(u3_mem_addr),
    .mem_wdata_o(u3_mem_wdata), .mem_rdata_i(mem_rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ce", mem_ce, 0); chk("rst_stall", stall, 0);
    chk("rst_ifdata", if_data, 0); chk("rst_drdata", d_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    tick(); rst = 1'b1; tick();

    // 1: fetch 0x4, WS=1
    if_req = 1'b1; if_addr = 32'h4; mem_rdata = 32'h34011100;
    #1 chk("t1_stall_pre", stall, 1);
    tick(); // edge N
    chk("t1_ce_n", mem_ce, 1); chk("t1_addr", mem_addr, 32'h4);
    chk("t1_sel", mem_sel, 4'hF); chk("t1_we", mem_we, 0);
    chk("t1_ack_n", if_ack, 0); chk("t1_stall_n", stall, 1);
    tick();
    chk("t1_ce_n1", mem_ce, 1); chk("t1_ack_n1", if_ack, 0);
    tick();
    chk("t1_ack", if_ack, 1); chk("t1_ce_resp", mem_ce, 0);
    chk("t1_data", if_data, 32'h34011100); chk("t1_stall_ack", stall, 0);
    chk("t1_dack", d_ack, 0);
    if_req = 1'b0;
    tick();
    chk("t1_ack_off", if_ack, 0);

    // 2: simultaneous fetch and data read; data first
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h100; mem_rdata = 32'h11112222;
    tick();
    chk("t2_addr_d", mem_addr, 32'h100); chk("t2_we", mem_we, 0);
    tick(); tick();
    chk("t2_dack", d_ack, 1); chk("t2_ifack0", if_ack, 0);
    chk("t2_drdata", d_rdata, 32'h11112222); chk("t2_ifdata_hold", if_data, 32'h34011100);
    chk("t2_stall", stall, 1);
    d_req = 1'b0; mem_rdata = 32'h33334444;
    tick();
    chk("t2_idle_ce", mem_ce, 0);
    tick();
    chk("t2_addr_if", mem_addr, 32'h8); chk("t2_ce_if", mem_ce, 1);
    tick(); chk("t2_ifack_n6", if_ack, 0);
    tick();
    chk("t2_ifack", if_ack, 1); chk("t2_ifdata", if_data, 32'h33334444);
    chk("t2_drdata_hold", d_rdata, 32'h11112222);
    if_req = 1'b0;
    tick();

    // 3: halfword write
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h10C; d_wdata = 32'hDEADBEEF;
    mem_rdata = 32'h55556666;
    tick();
    chk("t3_we", mem_we, 1); chk("t3_sel", mem_sel, 4'b0011);
    chk("t3_addr", mem_addr, 32'h10C); chk("t3_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("t3_we2", mem_we, 1);
    tick();
    chk("t3_dack", d_ack, 1); chk("t3_derr", d_err, 0);
    chk("t3_drdata_hold", d_rdata, 32'h11112222); chk("t3_we_resp", mem_we, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick(); tick();

    // 4: WS=0 and WS=3 latencies
    if_req0 = 1'b1; if_req3 = 1'b1; if_addr = 32'h20;
    tick(); // edge N
    chk("t4_u0_ack_n", u0_if_ack, 0); chk("t4_u0_ce_n", u0_mem_ce, 1);
    tick();
    chk("t4_u0_ack", u0_if_ack, 1); chk("t4_u0_data", u0_if_data, 32'h55556666);
    chk("t4_u3_ack_n1", u3_if_ack, 0);
    if_req0 = 1'b0;
    tick(); chk("t4_u3_ack_n2", u3_if_ack, 0);
    tick(); chk("t4_u3_ack_n3", u3_if_ack, 0); chk("t4_u3_ce_n3", u3_mem_ce, 1);
    tick(); chk("t4_u3_ack", u3_if_ack, 1); chk("t4_u3_ce_resp", u3_mem_ce, 0);
    if_req3 = 1'b0;
    tick();

    // 5: reset mid-access
    if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'hA5A5A5A5;
    tick();
    chk("t5_ce_pre", mem_ce, 1);
    rst = 1'b0;
    #1;
    chk("t5_ce_rst", mem_ce, 0); chk("t5_stall_rst", stall, 0);
    chk("t5_ifdata_rst", if_data, 0); chk("t5_drdata_rst", d_rdata, 0);
    chk("t5_addr_rst", mem_addr, 0);
    tick();
    chk("t5_ack_rst", if_ack, 0); chk("t5_ce_rst2", mem_ce, 0);
    #1 rst = 1'b1;
    tick();
    chk("t5_ce_after", mem_ce, 1); chk("t5_addr_after", mem_addr, 32'h40);
    tick(); tick();
    chk("t5_ack", if_ack, 1); chk("t5_data", if_data, 32'hA5A5A5A5);
    if_req = 1'b0;
    tick();

    // 6: misaligned word read at 0x102
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h102; mem_rdata = 32'h12345678;
    tick();
`ifdef MISALIGN_CHK_EN
    chk("t6_ce", mem_ce, 0); chk("t6_dack", d_ack, 1);
    chk("t6_derr", d_err, 1); chk("t6_drdata", d_rdata, 0);
    d_req = 1'b0;
    tick();
    chk("t6_dack_off", d_ack, 0);
`else
    chk("t6_ce", mem_ce, 1); chk("t6_addr", mem_addr, 32'h100);
    tick(); tick();
    chk("t6_dack", d_ack, 1); chk("t6_derr", d_err, 0);
    chk("t6_drdata", d_rdata, 32'h12345678);
    d_req = 1'b0;
    tick();
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
